// File: rtl/checker_pkg.sv
// rtl/checker_pkg.sv - shared constants, state type and helpers for the runtime checker
package checker_pkg;

    localparam int          REG_ID_PC       = 32;
    localparam int          REG_ID_MEM_BASE = 33;
    localparam logic [63:0] REG_ID_EMPTY    = '1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        CHECK,
        DONE
    } state_t;

    // Width of an index into n items, never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/check_table.sv
// rtl/check_table.sv - expected-value table with first-empty-slot fill and overflow flag
module check_table
    import checker_pkg::*;
#(
    parameter int ADDR_DEPTH      = 256,
    parameter int CHECKS_PER_ADDR = 3,
    parameter int REG_ID_WIDTH    = 6,
    parameter int DATA_WIDTH      = 32,
    localparam int IW             = idx_width(ADDR_DEPTH),
    localparam int SW             = idx_width(CHECKS_PER_ADDR)
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    clear,
    input  logic                    load_en,
    input  logic [29:0]             load_word,
    input  logic [REG_ID_WIDTH-1:0] load_reg,
    input  logic [DATA_WIDTH-1:0]   load_value,
    input  logic [IW-1:0]           q_idx,
    output logic [SW:0]             q_count,
    input  logic [IW-1:0]           rd_idx,
    input  logic [SW-1:0]           rd_slot,
    output logic [REG_ID_WIDTH-1:0] rd_reg,
    output logic [DATA_WIDTH-1:0]   rd_value,
    output logic [SW:0]             rd_count,
    output logic                    overflow
);

    localparam logic [REG_ID_WIDTH-1:0] EMPTY     = REG_ID_WIDTH'(REG_ID_EMPTY);
    localparam logic [29:0]             DEPTH_W   = 30'(ADDR_DEPTH);
    localparam logic [SW:0]             FULL_CNT  = (SW + 1)'(CHECKS_PER_ADDR);

    logic [REG_ID_WIDTH-1:0] slot_reg_q [ADDR_DEPTH][CHECKS_PER_ADDR];
    logic [DATA_WIDTH-1:0]   slot_val_q [ADDR_DEPTH][CHECKS_PER_ADDR];
    logic                    overflow_q, overflow_d;

    logic [IW-1:0] ld_idx;
    logic [SW:0]   ld_count;
    logic          ld_in_range;
    logic          wr_en;
    logic [SW-1:0] wr_slot;

    // Valid slots are contiguous from slot 0, so the count is also the first empty slot.
    function automatic logic [SW:0] count_of(input logic [IW-1:0] idx);
        logic [SW:0] cnt;
        cnt = '0;
        for (int c = 0; c < CHECKS_PER_ADDR; c++) begin
            if (slot_reg_q[idx][c] != EMPTY) begin
                cnt = cnt + 1'b1;
            end
        end
        return cnt;
    endfunction

    always_comb begin
        q_count  = count_of(q_idx);
        rd_count = count_of(rd_idx);
        rd_reg   = slot_reg_q[rd_idx][rd_slot];
        rd_value = slot_val_q[rd_idx][rd_slot];
    end

    always_comb begin
        ld_idx      = load_word[IW-1:0];
        ld_in_range = (load_word < DEPTH_W);
        ld_count    = count_of(ld_idx);
        wr_slot     = ld_count[SW-1:0];
        wr_en       = 1'b0;
        overflow_d  = overflow_q;
        if (load_en && (load_reg != EMPTY)) begin
            if (!ld_in_range || (ld_count == FULL_CNT)) begin
                overflow_d = 1'b1;
            end else begin
                wr_en = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < ADDR_DEPTH; i++) begin
                for (int c = 0; c < CHECKS_PER_ADDR; c++) begin
                    slot_reg_q[i][c] <= EMPTY;
                    slot_val_q[i][c] <= '0;
                end
            end
            overflow_q <= 1'b0;
        end else if (clear) begin
            for (int i = 0; i < ADDR_DEPTH; i++) begin
                for (int c = 0; c < CHECKS_PER_ADDR; c++) begin
                    slot_reg_q[i][c] <= EMPTY;
                end
            end
            overflow_q <= 1'b0;
        end else begin
            if (wr_en) begin
                slot_reg_q[ld_idx][wr_slot] <= load_reg;
                slot_val_q[ld_idx][wr_slot] <= load_value;
            end
            overflow_q <= overflow_d;
        end
    end

    assign overflow = overflow_q;

endmodule

// File: rtl/runtime_checker.sv
// rtl/runtime_checker.sv - retire-triggered register checker: FSM, counters and fail record
module runtime_checker
    import checker_pkg::*;
#(
    parameter int ADDR_DEPTH      = 256,
    parameter int CHECKS_PER_ADDR = 3,
    parameter int REG_ID_WIDTH    = 6,
    parameter int DATA_WIDTH      = 32,
    parameter int CNT_WIDTH       = 16
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    load_valid,
    input  logic [31:0]             load_addr,
    input  logic [REG_ID_WIDTH-1:0] load_reg,
    input  logic [DATA_WIDTH-1:0]   load_value,
    output logic                    load_ready,
    input  logic                    clear,
    input  logic                    start,
    input  logic [CNT_WIDTH-1:0]    cycle_limit,
    input  logic                    retire,
    input  logic [31:0]             retire_pc,
    output logic                    cpu_stall,
    output logic [REG_ID_WIDTH-1:0] obs_sel,
    input  logic [DATA_WIDTH-1:0]   obs_data,
    output logic [CNT_WIDTH-1:0]    pass_count,
    output logic [CNT_WIDTH-1:0]    fail_count,
    output logic                    fail_valid,
    output logic [31:0]             fail_addr,
    output logic [REG_ID_WIDTH-1:0] fail_reg,
    output logic [DATA_WIDTH-1:0]   fail_expected,
    output logic [DATA_WIDTH-1:0]   fail_actual,
    output logic                    table_overflow,
    output logic                    done
);

    localparam int          IW       = idx_width(ADDR_DEPTH);
    localparam int          SW       = idx_width(CHECKS_PER_ADDR);
    localparam logic [29:0] DEPTH_W  = 30'(ADDR_DEPTH);
    localparam logic [SW-1:0] LAST_SLOT = SW'(CHECKS_PER_ADDR - 1);

    state_t                  state_q, state_d;
    logic [CNT_WIDTH-1:0]    cycle_q, cycle_d;
    logic [CNT_WIDTH-1:0]    limit_q, limit_d;
    logic [CNT_WIDTH-1:0]    pass_q, pass_d;
    logic [CNT_WIDTH-1:0]    fail_q, fail_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [SW-1:0]           slot_q, slot_d;
    logic                    fail_valid_q, fail_valid_d;
    logic [31:0]             fail_addr_q, fail_addr_d;
    logic [REG_ID_WIDTH-1:0] fail_reg_q, fail_reg_d;
    logic [DATA_WIDTH-1:0]   fail_exp_q, fail_exp_d;
    logic [DATA_WIDTH-1:0]   fail_act_q, fail_act_d;

    logic [IW-1:0]           ret_idx;
    logic                    ret_in_range;
    logic [SW:0]             q_count;
    logic [REG_ID_WIDTH-1:0] rd_reg;
    logic [DATA_WIDTH-1:0]   rd_value;
    logic [SW:0]             rd_count;
    logic                    last_slot;
    logic                    unused_addr_bits;

    assign unused_addr_bits = ^{load_addr[1:0], retire_pc[1:0]};

    assign load_ready   = (state_q == IDLE) || (state_q == DONE);
    assign cpu_stall    = (state_q == CHECK);
    assign done         = (state_q == DONE);
    assign obs_sel      = cpu_stall ? rd_reg : '0;
    assign ret_idx      = retire_pc[IW+1:2];
    assign ret_in_range = (retire_pc[31:2] < DEPTH_W);
    assign last_slot    = (slot_q == LAST_SLOT) || (({1'b0, slot_q} + 1'b1) >= rd_count);

    check_table #(
        .ADDR_DEPTH      (ADDR_DEPTH),
        .CHECKS_PER_ADDR (CHECKS_PER_ADDR),
        .REG_ID_WIDTH    (REG_ID_WIDTH),
        .DATA_WIDTH      (DATA_WIDTH)
    ) u_table (
        .clock      (clock),
        .reset      (reset),
        .clear      (clear && load_ready),
        .load_en    (load_valid && load_ready),
        .load_word  (load_addr[31:2]),
        .load_reg   (load_reg),
        .load_value (load_value),
        .q_idx      (ret_idx),
        .q_count    (q_count),
        .rd_idx     (idx_q),
        .rd_slot    (slot_q),
        .rd_reg     (rd_reg),
        .rd_value   (rd_value),
        .rd_count   (rd_count),
        .overflow   (table_overflow)
    );

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    always_comb begin
        state_d      = state_q;
        cycle_d      = cycle_q;
        limit_d      = limit_q;
        pass_d       = pass_q;
        fail_d       = fail_q;
        idx_d        = idx_q;
        slot_d       = slot_q;
        fail_valid_d = 1'b0;
        fail_addr_d  = fail_addr_q;
        fail_reg_d   = fail_reg_q;
        fail_exp_d   = fail_exp_q;
        fail_act_d   = fail_act_q;
        case (state_q)
            IDLE, DONE: begin
                if (clear) begin
                    pass_d = '0;
                    fail_d = '0;
                end
                if (start) begin
                    state_d = RUN;
                    cycle_d = '0;
                    limit_d = cycle_limit;
                end
            end
            RUN: begin
                cycle_d = sat_inc(cycle_q);
                // >= rather than == so a check straddling the limit still ends the run.
                if (retire && ret_in_range && (q_count != '0)) begin
                    state_d = CHECK;
                    idx_d   = ret_idx;
                    slot_d  = '0;
                end else if (cycle_q >= limit_q) begin
                    state_d = DONE;
                end
            end
            CHECK: begin
                if (obs_data == rd_value) begin
                    pass_d = sat_inc(pass_q);
                end else begin
                    fail_d       = sat_inc(fail_q);
                    fail_valid_d = 1'b1;
                    fail_addr_d  = 32'({idx_q, 2'b00});
                    fail_reg_d   = rd_reg;
                    fail_exp_d   = rd_value;
                    fail_act_d   = obs_data;
                end
                if (last_slot) begin
                    state_d = RUN;
                end else begin
                    slot_d = slot_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            cycle_q      <= '0;
            limit_q      <= '0;
            pass_q       <= '0;
            fail_q       <= '0;
            idx_q        <= '0;
            slot_q       <= '0;
            fail_valid_q <= 1'b0;
            fail_addr_q  <= '0;
            fail_reg_q   <= '0;
            fail_exp_q   <= '0;
            fail_act_q   <= '0;
        end else begin
            state_q      <= state_d;
            cycle_q      <= cycle_d;
            limit_q      <= limit_d;
            pass_q       <= pass_d;
            fail_q       <= fail_d;
            idx_q        <= idx_d;
            slot_q       <= slot_d;
            fail_valid_q <= fail_valid_d;
            fail_addr_q  <= fail_addr_d;
            fail_reg_q   <= fail_reg_d;
            fail_exp_q   <= fail_exp_d;
            fail_act_q   <= fail_act_d;
        end
    end

    assign pass_count    = pass_q;
    assign fail_count    = fail_q;
    assign fail_valid    = fail_valid_q;
    assign fail_addr     = fail_addr_q;
    assign fail_reg      = fail_reg_q;
    assign fail_expected = fail_exp_q;
    assign fail_actual   = fail_act_q;

endmodule

// File: doc/runtime_checker.md
# runtime_checker

Synthesizable, parametrised successor of the runtime register-check bench: holds an expected-value table indexed by instruction address, watches the CPU retire stream, and on each retirement at a tagged address stalls the core and compares up to `CHECKS_PER_ADDR` observed register, PC or memory values against the table. It sits beside `risc_v_cpu`, drives the core's stall, and reads architectural state through an external observation mux. It reports pass/fail counts, first-class fail records and a cycle-budget end-of-run.

## Interface
- `ADDR_DEPTH`, 256: table entries, indexed by `retire_pc / 4`.
- `CHECKS_PER_ADDR`, 3: check slots per entry.
- `REG_ID_WIDTH`, 6: selector width; 0–31 = GPR, 32 = PC, 33+ = memory word `(id − 33)`.
- `DATA_WIDTH`, 32: value width.
- `CNT_WIDTH`, 16: width of the cycle limit and of the counters.
- `clock  in  1`: single clock domain.
- `reset  in  1`: asynchronous, active-low.
- `load_valid  in  1`, `load_addr  in  32` (byte address), `load_reg  in  REG_ID_WIDTH`, `load_value  in  DATA_WIDTH`: table load.
- `load_ready  out  1`: high in IDLE/DONE.
- `clear  in  1`: empties the table and zeroes the counters; accepted only in IDLE/DONE.
- `start  in  1`, `cycle_limit  in  CNT_WIDTH`: begin a run.
- `retire  in  1`, `retire_pc  in  32`: one-cycle commit pulse and the PC of the committed instruction.
- `cpu_stall  out  1`: freezes the core.
- `obs_sel  out  REG_ID_WIDTH`, `obs_data  in  DATA_WIDTH`: combinational observation port.
- `pass_count`, `fail_count  out  CNT_WIDTH`: result counters.
- `fail_valid  out  1`, `fail_addr  out  32`, `fail_reg  out  REG_ID_WIDTH`, `fail_expected`, `fail_actual  out  DATA_WIDTH`: fail record.
- `table_overflow  out  1`, `done  out  1`: status flags.

## Operation
- Empty slot encoding: `reg id = all-ones`. After reset and after `clear`, every slot is empty.
- **Load** (accepted when `load_valid && load_ready`):
  - Writes to the lowest empty slot of entry `load_addr/4`, so valid slots are always contiguous from slot 0.
  - If the entry is full, or `load_addr/4 >= ADDR_DEPTH`, the write is dropped and `table_overflow` sets sticky until `clear`.
  - `load_reg = all-ones` is dropped silently.
- **FSM: IDLE → RUN → CHECK ↔ RUN → DONE.**
  - IDLE: `start` → RUN. The cycle counter loads 0.
  - RUN:
    - The counter increments each cycle.
    - `retire` with `retire_pc/4 < ADDR_DEPTH` and slot 0 valid → latch the index, go to CHECK with slot pointer 0.
    - Otherwise, when the counter reaches `cycle_limit` → DONE.
    - `retire` has priority over the limit in the same cycle.
  - CHECK:
    - `cpu_stall = 1`. One slot is processed per cycle: `obs_sel` = slot reg id, and `obs_data` is compared in the same cycle.
    - Equal → `pass_count++`. Different → `fail_count++` and a fail record is issued.
    - After the last valid slot (or slot `CHECKS_PER_ADDR − 1`) → RUN.
    - The cycle counter holds during CHECK.
  - DONE: `done = 1`. `start` → RUN with the counter reloaded to 0. The table and counters are preserved (`clear` first for a fresh run).
- `start` in RUN/CHECK and `load_valid`/`clear` in RUN/CHECK are ignored.
- `retire` during CHECK is a protocol violation; it is ignored.
- Counters saturate at all-ones.
- `obs_sel` is 0 outside CHECK.

## Timing
- Reset values:
  - State IDLE.
  - All counters 0.
  - `cpu_stall`, `fail_valid`, `done`, `table_overflow` = 0.
  - Fail-record fields 0.
  - `load_ready` = 1.
  - All table slots empty.
- `retire` at edge N → CHECK from N+1. `cpu_stall` is a decode of the state, so it is high in cycle N+1; the core holds from edge N+1.
- A check of k slots holds stall for exactly k cycles; the core resumes k+1 cycles after `retire`.
- `fail_valid` is a registered one-cycle pulse, one cycle after the failing compare. The record fields hold until the next fail.
- Load write is visible to a compare from the next cycle.
- `done` rises the cycle after the counter equals `cycle_limit`. With `cycle_limit = 0`, DONE is reached after one RUN cycle.
- Asynchronous reset mid-CHECK aborts the check immediately and releases the stall.

## Structure
- Package `checker_pkg`:
  - Constants `REG_ID_EMPTY`, `REG_ID_PC = 32`, `REG_ID_MEM_BASE = 33`.
  - State enum `{IDLE, RUN, CHECK, DONE}`.
- Sub-module `check_table`:
  - Storage (flops), first-empty-slot fill logic, overflow detection.
  - Read port by index and slot.
  - Per-entry valid-count output.
- The top level holds the FSM, the counters and the fail-record registers.

## Test plan
- **Load + pass:** load `0x8:5=42` and `0x8:6=7`; start with limit 100; retire pc `0x8` with `obs` x5 = 42, x6 = 7 → stall for exactly 2 cycles, `pass_count = 2`, `fail_count = 0`.
- **Fail record:** load `0x10:3=1`; retire pc `0x10` with x3 = 9 → `fail_valid` pulses once with addr `0x10`, reg 3, expected 1, actual 9; `fail_count = 1`.
- **Overflow:** load 4 checks to address `0x0` with `CHECKS_PER_ADDR = 3` → the 4th is dropped and `table_overflow = 1`. Also load addr `0x400` (index 256) → dropped.
- **Untagged / out-of-range retire:** retire pc `0x4` (empty entry) and pc `0x1000` → no stall, counters unchanged.
- **Limit:** limit 10, no retires → `done` high on cycle 11. `retire` coinciding with counter = 10 → CHECK first, then DONE.
- **Reset mid-CHECK:** assert reset during the second slot → all outputs at reset values, stall low, table empty.
